// File: rtl/buffered_channel_controller_pkg.sv
// Shared opcodes, FSM states and per-command action codes for the buffered channel controller.
// The opcodes and CHANNEL_NONE here are the channels.vh definitions carried into a package.
package buffered_channel_controller_pkg;

    localparam logic [3:0] CREATE_CHANNEL  = 4'd1;
    localparam logic [3:0] DESTROY_CHANNEL = 4'd2;
    localparam logic [3:0] SEND_MESSAGE    = 4'd3;
    localparam logic [3:0] RECEIVE_MESSAGE = 4'd4;

    // All-ones channel id meaning "no channel"; cast to the id width where used.
    localparam int CHANNEL_NONE = -1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        READ = 2'd2
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ACT_NONE,
        ACT_ERROR,
        ACT_CREATE,
        ACT_DESTROY,
        ACT_DELIVER,
        ACT_ENQUEUE,
        ACT_BLOCK_SEND,
        ACT_BLOCK_RECV,
        ACT_FETCH,
        ACT_DEQUEUE
    } chan_action_t;

endpackage

// File: rtl/buffered_channel_controller_channel_buffer_ram.sv
// Message storage for all channels: one word per {channel, slot}, one synchronous read
// port and one write port.
module channel_buffer_ram
    import buffered_channel_controller_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 4,
    parameter int DATA_BITS    = 16,
    parameter int CH_W         = 2,
    parameter int SLOT_W       = 2
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_channel,
    input  logic [SLOT_W-1:0]    wr_slot,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [CH_W-1:0]      rd_channel,
    input  logic [SLOT_W-1:0]    rd_slot,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [NUM_CHANNELS][DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_channel][wr_slot] <= wr_data;
        end
        rd_data <= mem[rd_channel][rd_slot];
    end

endmodule

// File: rtl/buffered_channel_controller.sv
// Buffered occam channel controller: one command in (enabled), one result out (finished),
// with per-channel FIFOs in channel_buffer_ram and all control state held in flops here.
module buffered_channel_controller
    import buffered_channel_controller_pkg::*;
#(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enabled,
    input  logic [3:0]           channelOperationIn,
    input  logic [ADDR_BITS-1:0] channelIn,
    input  logic [DATA_BITS-1:0] messageIn,
    input  logic [ADDR_BITS-1:0] pidIn,
    output logic                 finished,
    output logic                 hasChannelOut,
    output logic [ADDR_BITS-1:0] channelOut,
    output logic                 hasMessageOut,
    output logic [DATA_BITS-1:0] messageOut,
    output logic                 hasSchedulePidOut,
    output logic [ADDR_BITS-1:0] schedulePidOut,
    output logic                 hasDeschedulePidOut,
    output logic [ADDR_BITS-1:0] deschedulePidOut,
    output logic                 errorOut,
    output ctrl_state_t          fsm_state
);

    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    ctrl_state_t  state, state_next;
    chan_action_t action;

    logic [3:0]           op_q;
    logic [ADDR_BITS-1:0] ch_q;
    logic [DATA_BITS-1:0] msg_q;
    logic [ADDR_BITS-1:0] pid_q;

    logic                 alloc     [NUM_CHANNELS];
    logic [CNT_W-1:0]     count     [NUM_CHANNELS];
    logic [SLOT_W-1:0]    head      [NUM_CHANNELS];
    logic [SLOT_W-1:0]    tail      [NUM_CHANNELS];
    logic                 send_wait [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] send_pid  [NUM_CHANNELS];
    logic [DATA_BITS-1:0] send_msg  [NUM_CHANNELS];
    logic                 recv_wait [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] recv_pid  [NUM_CHANNELS];

    logic [CH_W-1:0]      cidx;
    logic                 sel_ok;
    logic                 free_found;
    logic [ADDR_BITS-1:0] free_idx;
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] rd_data;

    // Explicit compare-and-reset so non-power-of-two depths wrap correctly.
    function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] p);
        return (p == SLOT_W'(DEPTH - 1)) ? '0 : p + SLOT_W'(1);
    endfunction

    assign fsm_state = state;
    assign cidx      = ch_q[CH_W-1:0];
    assign sel_ok    = ({1'b0, ch_q} < (ADDR_BITS + 1)'(NUM_CHANNELS)) && alloc[cidx];

    always_comb begin
        free_found = 1'b0;
        free_idx   = ADDR_BITS'(CHANNEL_NONE);
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (!alloc[i]) begin
                free_found = 1'b1;
                free_idx   = ADDR_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        action     = ACT_NONE;
        case (state)
            IDLE: if (enabled) state_next = EXEC;
            EXEC: begin
                state_next = IDLE;
                case (op_q)
                    CREATE_CHANNEL:  action = free_found ? ACT_CREATE : ACT_ERROR;
                    DESTROY_CHANNEL: action = (!sel_ok || send_wait[cidx] || recv_wait[cidx])
                                              ? ACT_ERROR : ACT_DESTROY;
                    SEND_MESSAGE: begin
                        if (!sel_ok)                           action = ACT_ERROR;
                        else if (recv_wait[cidx])              action = ACT_DELIVER;
                        else if (count[cidx] < CNT_W'(DEPTH))  action = ACT_ENQUEUE;
                        else if (send_wait[cidx])              action = ACT_ERROR;
                        else                                   action = ACT_BLOCK_SEND;
                    end
                    RECEIVE_MESSAGE: begin
                        if (!sel_ok)                  action = ACT_ERROR;
                        else if (count[cidx] != '0) begin
                            action     = ACT_FETCH;
                            state_next = READ;
                        end
                        else if (recv_wait[cidx])     action = ACT_ERROR;
                        else                          action = ACT_BLOCK_RECV;
                    end
                    default: action = ACT_ERROR;
                endcase
            end
            READ: begin
                state_next = IDLE;
                action     = ACT_DEQUEUE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A blocked sender's message lands in the slot just freed; in a full FIFO tail == head,
    // and the head word was already read during EXEC, so the write cannot clobber it.
    assign wr_en   = (action == ACT_ENQUEUE) || (action == ACT_DEQUEUE && send_wait[cidx]);
    assign wr_data = (action == ACT_ENQUEUE) ? msg_q : send_msg[cidx];

    channel_buffer_ram #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .DEPTH       (DEPTH),
        .DATA_BITS   (DATA_BITS),
        .CH_W        (CH_W),
        .SLOT_W      (SLOT_W)
    ) u_ram (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_channel(cidx),
        .wr_slot   (tail[cidx]),
        .wr_data   (wr_data),
        .rd_channel(cidx),
        .rd_slot   (head[cidx]),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                alloc[i]     <= 1'b0;
                count[i]     <= '0;
                head[i]      <= '0;
                tail[i]      <= '0;
                send_wait[i] <= 1'b0;
                send_pid[i]  <= '0;
                send_msg[i]  <= '0;
                recv_wait[i] <= 1'b0;
                recv_pid[i]  <= '0;
            end
        end else begin
            case (action)
                ACT_CREATE: begin
                    alloc[free_idx[CH_W-1:0]]     <= 1'b1;
                    count[free_idx[CH_W-1:0]]     <= '0;
                    head[free_idx[CH_W-1:0]]      <= '0;
                    tail[free_idx[CH_W-1:0]]      <= '0;
                    send_wait[free_idx[CH_W-1:0]] <= 1'b0;
                    recv_wait[free_idx[CH_W-1:0]] <= 1'b0;
                end
                ACT_DESTROY: alloc[cidx] <= 1'b0;
                ACT_DELIVER: recv_wait[cidx] <= 1'b0;
                ACT_ENQUEUE: begin
                    tail[cidx]  <= slot_next(tail[cidx]);
                    count[cidx] <= count[cidx] + CNT_W'(1);
                end
                ACT_BLOCK_SEND: begin
                    send_wait[cidx] <= 1'b1;
                    send_pid[cidx]  <= pid_q;
                    send_msg[cidx]  <= msg_q;
                end
                ACT_BLOCK_RECV: begin
                    recv_wait[cidx] <= 1'b1;
                    recv_pid[cidx]  <= pid_q;
                end
                ACT_DEQUEUE: begin
                    head[cidx] <= slot_next(head[cidx]);
                    if (send_wait[cidx]) begin
                        tail[cidx]      <= slot_next(tail[cidx]);
                        send_wait[cidx] <= 1'b0;
                    end else begin
                        count[cidx] <= count[cidx] - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q                <= '0;
            ch_q                <= '0;
            msg_q               <= '0;
            pid_q               <= '0;
            finished            <= 1'b0;
            hasChannelOut       <= 1'b0;
            channelOut          <= '0;
            hasMessageOut       <= 1'b0;
            messageOut          <= '0;
            hasSchedulePidOut   <= 1'b0;
            schedulePidOut      <= '0;
            hasDeschedulePidOut <= 1'b0;
            deschedulePidOut    <= '0;
            errorOut            <= 1'b0;
        end else if (state == IDLE) begin
            if (enabled) begin
                op_q                <= channelOperationIn;
                ch_q                <= channelIn;
                msg_q               <= messageIn;
                pid_q               <= pidIn;
                finished            <= 1'b0;
                hasChannelOut       <= 1'b0;
                hasMessageOut       <= 1'b0;
                hasSchedulePidOut   <= 1'b0;
                hasDeschedulePidOut <= 1'b0;
                errorOut            <= 1'b0;
            end
        end else begin
            if (state_next == IDLE) finished <= 1'b1;
            case (action)
                ACT_ERROR: errorOut <= 1'b1;
                ACT_CREATE: begin
                    hasChannelOut <= 1'b1;
                    channelOut    <= free_idx;
                end
                ACT_DELIVER: begin
                    hasMessageOut     <= 1'b1;
                    messageOut        <= msg_q;
                    hasSchedulePidOut <= 1'b1;
                    schedulePidOut    <= recv_pid[cidx];
                end
                ACT_BLOCK_SEND, ACT_BLOCK_RECV: begin
                    hasDeschedulePidOut <= 1'b1;
                    deschedulePidOut    <= pid_q;
                end
                ACT_DEQUEUE: begin
                    hasMessageOut <= 1'b1;
                    messageOut    <= rd_data;
                    if (send_wait[cidx]) begin
                        hasSchedulePidOut <= 1'b1;
                        schedulePidOut    <= send_pid[cidx];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/buffered_channel_controller.md
# buffered_channel_controller

Parametrised successor to the rendezvous channel controller. It manages `NUM_CHANNELS` occam-style channels, each with a `DEPTH`-slot message FIFO, so senders block only when a channel is full. It sits between the core message decoder and the scheduler on the same command/result interface: one command in, then schedule/deschedule/message results out. Alternation operations are out of scope for this block.

## Interface
- `ADDR_BITS`, 8: channel id and pid width.
- `DATA_BITS`, 16: message width.
- `NUM_CHANNELS`, 4: channel count, at most 2^`ADDR_BITS`.
- `DEPTH`, 4: FIFO slots per channel, at least 1.

- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `enabled` in 1: command valid.
- `channelOperationIn` in 4: `CREATE_CHANNEL`, `DESTROY_CHANNEL`, `SEND_MESSAGE`, `RECEIVE_MESSAGE` from `channels.vh`.
- `channelIn` in `ADDR_BITS`: target channel.
- `messageIn` in `DATA_BITS`: send payload.
- `pidIn` in `ADDR_BITS`: issuing process.
- `finished` out 1: result valid.
- `hasChannelOut`, `channelOut` out 1/`ADDR_BITS`: created channel id.
- `hasMessageOut`, `messageOut` out 1/`DATA_BITS`: received message.
- `hasSchedulePidOut`, `schedulePidOut` out 1/`ADDR_BITS`: process to wake.
- `hasDeschedulePidOut`, `deschedulePidOut` out 1/`ADDR_BITS`: process to block.
- `errorOut` out 1: illegal command; no state changed.

## Operation
- **Per-channel state:** `alloc`, `count` (0..`DEPTH`), `head`, `tail`, `sendWait` + `sendPid` + `sendMsg`, `recvWait` + `recvPid`.
- **CREATE:** allocates the lowest free index and clears its state.
  - Result: `hasChannelOut`=1, `channelOut`=index.
  - None free: `errorOut`.
- **SEND:**
  - `recvWait` set: deliver directly. `messageOut`=`messageIn`, schedule `recvPid`, clear `recvWait`.
  - Else if `count`<`DEPTH`: enqueue at `tail`; no schedule, no deschedule.
  - Else (full): latch `sendPid`/`sendMsg`, set `sendWait`, deschedule `pidIn`.
- **RECEIVE:**
  - `count`>0: dequeue `head` into `messageOut`. If `sendWait` is set, enqueue `sendMsg` in the freed slot in the same operation, schedule `sendPid`, clear `sendWait`; `count` is unchanged.
  - `count`=0: set `recvWait`, `recvPid`=`pidIn`, deschedule `pidIn`.
- **DESTROY:** clears `alloc`. Any buffered messages are discarded.
- **Error cases:** `channelIn`≥`NUM_CHANNELS`, channel unallocated, second blocked sender or receiver, DESTROY while `sendWait`/`recvWait`, unknown op. Each asserts `errorOut` only.
- **Pointer arithmetic:** pointers wrap modulo `DEPTH`. Non-power-of-two `DEPTH` uses explicit compare-and-reset, not bit truncation.

## Timing
- **Reset:** all outputs 0, including `finished`; all channels free.
- **FSM `IDLE`:** `enabled`=1 at a clock edge latches the inputs, clears all `has*` and `errorOut`, drops `finished`, and goes to `EXEC`.
- **FSM `EXEC`:** storage read and the state update happen in one cycle, plus one cycle for the storage read in `READ` on RECEIVE. Then `finished`=1 and the FSM returns to `IDLE`.
- **Latency:** enable-to-`finished` is 2 cycles, or 3 for RECEIVE with `count`>0.
- **Output hold:** results hold until the next command is accepted.
- **Handshake:** the requester drops `enabled` the cycle `finished` rises. If `enabled` is still high in `IDLE`, the command is re-executed.
- **Reset mid-operation:** the command is abandoned, `finished`=0, and channel state clears immediately.

## Structure
- Opcodes stay in `channels.vh`; add `CHANNEL_NONE` (all-ones id) there.
- Sub-module `channel_buffer_ram`: `NUM_CHANNELS`×`DEPTH` words of `DATA_BITS`, one synchronous read port and one write port, addressed by {channel, slot}.
- Control state lives in flops inside the controller.

## Test plan
- **Create:** `NUM_CHANNELS`=2, `DEPTH`=2. Create three times → channel 0, then 1, then `errorOut` on the third.
- **Buffered send:** SEND 10, 20 (pid 4) on channel 0 → no deschedules. RECEIVE (pid 2) → 10, then 20.
- **Full channel:** SEND 10, 20, 30 (pid 4) → third deschedules pid 4. RECEIVE → message 10 and schedule pid 4. RECEIVE twice more → 20, then 30.
- **Blocked receiver:** RECEIVE on empty channel (pid 3) → deschedule 3. SEND 42 (pid 5) → `messageOut`=42, schedule 3, no deschedule.
- **Illegal commands:** DESTROY with pid 3 blocked → `errorOut`, channel intact. SEND to channel 7 → `errorOut`.
- **Reset mid-RECEIVE:** assert `reset` low during `EXEC` → all outputs 0. CREATE afterwards → channel 0.
